// File: rtl/issue_ctrl_pkg.sv
// Shared widths, opcode constants, queue entry layout and the issue-unit
// classifier for the instruction issue stage.
package issue_ctrl_pkg;

  localparam int INST_WID = 32;
  localparam int ADDR_WID = 32;
  localparam int ROB_SIZE = 16;
  localparam int ROB_WID  = 4;

  localparam logic [6:0] OPCODE_L     = 7'b0000011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
  localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

  typedef struct packed {
    logic [INST_WID-1:0] inst;
    logic [ADDR_WID-1:0] pc;
    logic                pre_j;
  } iq_entry_t;

  typedef enum logic [1:0] {
    UNIT_ROB = 2'd0,
    UNIT_RS  = 2'd1,
    UNIT_LSB = 2'd2
  } unit_t;

  // LUI, JAL and unknown opcodes need only a ROB slot.
  function automatic unit_t classify(input logic [6:0] opcode);
    unit_t unit;
    case (opcode)
      OPCODE_L, OPCODE_S:                                         unit = UNIT_LSB;
      OPCODE_CAL, OPCODE_CALI, OPCODE_B, OPCODE_AUIPC, OPCODE_JALR: unit = UNIT_RS;
      default:                                                    unit = UNIT_ROB;
    endcase
    return unit;
  endfunction

endpackage

// File: rtl/issue_ctrl_inst_queue.sv
// In-order circular instruction queue between IFetch and the issue logic.
// Callers gate push/pop/flush; the head entry is always visible on rd_data.
module issue_ctrl_inst_queue
  import issue_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = 16,
  parameter int IQ_WID   = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  iq_entry_t wr_data,
  output iq_entry_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam logic [IQ_WID:0] DEPTH_CNT = IQ_DEPTH[IQ_WID:0];

  logic [IQ_WID-1:0] head;
  logic [IQ_WID-1:0] tail;
  logic [IQ_WID:0]   count;
  iq_entry_t         mem [IQ_DEPTH];

  // Pointers wrap naturally because IQ_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: buffers fetched instructions, allocates ROB tail slots and
// strobes one instruction per cycle to Decoder when ROB and target unit accept.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = 16,
  parameter int IQ_WID   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                if_valid,
  input  logic [INST_WID-1:0] if_inst,
  input  logic [ADDR_WID-1:0] if_pc,
  input  logic                if_pre_j,
  output logic                if_ready,
  input  logic                rob_full,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic                dec_valid,
  output logic [INST_WID-1:0] dec_inst,
  output logic [ADDR_WID-1:0] dec_pc,
  output logic                dec_pre_j,
  output logic [ROB_WID-1:0]  dec_rob_pos,
  output logic                dec_to_rs,
  output logic                dec_to_lsb
);

  localparam logic [ROB_WID-1:0] ROB_LAST = ROB_WID'(ROB_SIZE - 1);

  iq_entry_t          wr_entry;
  iq_entry_t          head_entry;
  logic               iq_full;
  logic               iq_empty;
  unit_t              head_unit;
  logic               can_issue;
  logic               do_push;
  logic               do_issue;
  logic               do_flush;
  logic [ROB_WID-1:0] rob_tail;

  assign wr_entry = '{inst: if_inst, pc: if_pc, pre_j: if_pre_j};

  assign head_unit = classify(head_entry.inst[6:0]);
  assign can_issue = !iq_empty && !rob_full
                     && !(head_unit == UNIT_RS  && rs_full)
                     && !(head_unit == UNIT_LSB && lsb_full);

  // Rollback beats push and issue; rdy low freezes everything, rollback included.
  assign do_flush = rdy && rollback;
  assign do_push  = rdy && !rollback && if_valid && !iq_full;
  assign do_issue = rdy && !rollback && can_issue;
  assign if_ready = !iq_full;

  issue_ctrl_inst_queue #(
    .IQ_DEPTH (IQ_DEPTH),
    .IQ_WID   (IQ_WID)
  ) inst_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (do_push),
    .pop     (do_issue),
    .flush   (do_flush),
    .wr_data (wr_entry),
    .rd_data (head_entry),
    .full    (iq_full),
    .empty   (iq_empty)
  );

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_tail    <= '0;
      dec_valid   <= 1'b0;
      dec_inst    <= '0;
      dec_pc      <= '0;
      dec_pre_j   <= 1'b0;
      dec_rob_pos <= '0;
      dec_to_rs   <= 1'b0;
      dec_to_lsb  <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        rob_tail  <= '0;
        dec_valid <= 1'b0;
      end else if (can_issue) begin
        dec_valid   <= 1'b1;
        dec_inst    <= head_entry.inst;
        dec_pc      <= head_entry.pc;
        dec_pre_j   <= head_entry.pre_j;
        dec_rob_pos <= rob_tail;
        dec_to_rs   <= (head_unit == UNIT_RS);
        dec_to_lsb  <= (head_unit == UNIT_LSB);
        rob_tail    <= (rob_tail == ROB_LAST) ? '0 : rob_tail + 1'b1;
      end else begin
        dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: a directed vector table followed by
// hand-written multi-cycle sequences (reset, streaming, stalls, rollback, rdy).
module tb_issue_ctrl;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_ADD  = 32'h002081b3;
  localparam logic [31:0] I_LW   = 32'h0000a103;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_LUI  = 32'h000010b7;
  localparam logic [31:0] I_JAL  = 32'h0000006f;
  localparam logic [31:0] I_UNK  = 32'h0000007f;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_pre_j;
  logic        if_ready;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pre_j;
  logic [3:0]  dec_rob_pos;
  logic        dec_to_rs;
  logic        dec_to_lsb;

  int n_cmp = 0;
  int n_err = 0;

  issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pre_j    (if_pre_j),
    .if_ready    (if_ready),
    .rob_full    (rob_full),
    .rs_full     (rs_full),
    .lsb_full    (lsb_full),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_pre_j   (dec_pre_j),
    .dec_rob_pos (dec_rob_pos),
    .dec_to_rs   (dec_to_rs),
    .dec_to_lsb  (dec_to_lsb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rollback, if_valid;
    logic [31:0] inst, pc;
    logic        pre_j, rob_full, rs_full, lsb_full;
    logic        e_valid;
    logic [31:0] e_inst, e_pc;
    logic        e_pre_j;
    logic [3:0]  e_pos;
    logic        e_rs, e_lsb, e_ready;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue strobe with the fields that matter for an issued instruction.
  task automatic check_issue(input string name, input logic [31:0] pc, input logic [3:0] pos,
                             input logic to_rs, input logic to_lsb);
    check({name, ".valid"}, 64'(dec_valid), 64'(1'b1));
    check({name, ".pc"}, 64'(dec_pc), 64'(pc));
    check({name, ".rob_pos"}, 64'(dec_rob_pos), 64'(pos));
    check({name, ".to_rs"}, 64'(dec_to_rs), 64'(to_rs));
    check({name, ".to_lsb"}, 64'(dec_to_lsb), 64'(to_lsb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    if_pre_j = 1'b0;
  endtask

  task automatic check_dec_zero(input string name);
    check({name, ".valid"}, 64'(dec_valid), 64'(1'b0));
    check({name, ".inst"}, 64'(dec_inst), 64'(0));
    check({name, ".pc"}, 64'(dec_pc), 64'(0));
    check({name, ".pre_j"}, 64'(dec_pre_j), 64'(1'b0));
    check({name, ".rob_pos"}, 64'(dec_rob_pos), 64'(0));
    check({name, ".to_rs"}, 64'(dec_to_rs), 64'(1'b0));
    check({name, ".to_lsb"}, 64'(dec_to_lsb), 64'(1'b0));
    check({name, ".if_ready"}, 64'(if_ready), 64'(1'b1));
  endtask

  initial begin
    // rdy rb  v  inst    pc        pj rf rs ls | ev e_inst  e_pc      epj pos rs lsb rdy
    vecs[0] = '{1, 0, 1, I_LUI,  32'h100, 0, 0, 0, 0,  0, 32'h0, 32'h0,   0, 0, 0, 0, 1};
    vecs[1] = '{1, 0, 1, I_SW,   32'h104, 1, 0, 0, 0,  1, I_LUI, 32'h100, 0, 0, 0, 0, 1};
    vecs[2] = '{1, 0, 1, I_BEQ,  32'h108, 1, 0, 0, 0,  1, I_SW,  32'h104, 1, 1, 0, 1, 1};
    vecs[3] = '{1, 0, 0, 32'h0,  32'h0,   0, 0, 1, 0,  0, I_SW,  32'h104, 1, 1, 0, 1, 1};
    vecs[4] = '{1, 0, 0, 32'h0,  32'h0,   0, 0, 0, 1,  1, I_BEQ, 32'h108, 1, 2, 1, 0, 1};
    vecs[5] = '{1, 0, 1, I_UNK,  32'h10c, 0, 0, 1, 1,  0, I_BEQ, 32'h108, 1, 2, 1, 0, 1};
    vecs[6] = '{1, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1,  1, I_UNK, 32'h10c, 0, 3, 0, 0, 1};
    vecs[7] = '{0, 0, 1, I_ADDI, 32'h110, 0, 0, 0, 0,  1, I_UNK, 32'h10c, 0, 3, 0, 0, 1};
    vecs[8] = '{1, 0, 0, 32'h0,  32'h0,   0, 0, 0, 0,  0, I_UNK, 32'h10c, 0, 3, 0, 0, 1};

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_dec_zero("reset");
    rst = 1'b0;

    // Directed vector table: classification, stalls, hold behaviour, rdy freeze.
    for (int i = 0; i < 9; i++) begin
      rdy = vecs[i].rdy; rollback = vecs[i].rollback;
      if_valid = vecs[i].if_valid; if_inst = vecs[i].inst;
      if_pc = vecs[i].pc; if_pre_j = vecs[i].pre_j;
      rob_full = vecs[i].rob_full; rs_full = vecs[i].rs_full; lsb_full = vecs[i].lsb_full;
      tick();
      check($sformatf("vec%0d.valid", i), 64'(dec_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d.inst", i), 64'(dec_inst), 64'(vecs[i].e_inst));
      check($sformatf("vec%0d.pc", i), 64'(dec_pc), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d.pre_j", i), 64'(dec_pre_j), 64'(vecs[i].e_pre_j));
      check($sformatf("vec%0d.rob_pos", i), 64'(dec_rob_pos), 64'(vecs[i].e_pos));
      check($sformatf("vec%0d.to_rs", i), 64'(dec_to_rs), 64'(vecs[i].e_rs));
      check($sformatf("vec%0d.to_lsb", i), 64'(dec_to_lsb), 64'(vecs[i].e_lsb));
      check($sformatf("vec%0d.if_ready", i), 64'(if_ready), 64'(vecs[i].e_ready));
    end
    rdy = 1'b1; rs_full = 1'b0; lsb_full = 1'b0;

    // Reset mid-stream: 6 queued behind rob_full, JAL issues leaving 5 queued.
    rob_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k == 0) ? I_JAL : I_ADDI, 32'h20 + 32'(4 * k));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    rob_full = 1'b0; rs_full = 1'b1;
    tick();
    check_issue("midrst_pre", 32'h20, 4'd4, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_dec_zero("midrst");
    #1;
    rst = 1'b0; rs_full = 1'b0;
    drive(1'b1, I_ADDI, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_issue("midrst_post", 32'h0, 4'd0, 1'b1, 1'b0);

    // 20 back-to-back ADDI from a fresh reset.
    rst = 1'b1; #2; rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      drive(i < 20, I_ADDI, 32'h1000 + 32'(4 * i));
      tick();
      check($sformatf("stream%0d.if_ready", i), 64'(if_ready), 64'(1'b1));
      if (i == 0 || i == 21)
        check($sformatf("stream%0d.valid", i), 64'(dec_valid), 64'(1'b0));
      else
        check_issue($sformatf("stream%0d", i), 32'h1000 + 32'(4 * (i - 1)), 4'((i - 1) % 16),
                    1'b1, 1'b0);
    end

    // LW blocked by lsb_full until the queue fills; then in-order drain.
    lsb_full = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, (k == 0) ? I_LW : ((k == 1) ? I_ADD : I_ADDI), 32'h10 + 32'(4 * k));
      tick();
      check($sformatf("lsbfill%0d.valid", k), 64'(dec_valid), 64'(1'b0));
    end
    check("lsbfill.if_ready", 64'(if_ready), 64'(1'b0));
    drive(1'b1, I_ADDI, 32'hdead);
    tick();
    check("lsbfull_push.valid", 64'(dec_valid), 64'(1'b0));
    check("lsbfull_push.if_ready", 64'(if_ready), 64'(1'b0));
    drive(1'b0, 32'h0, 32'h0);
    lsb_full = 1'b0;
    tick();
    check_issue("lsb_lw", 32'h10, 4'd4, 1'b0, 1'b1);
    check("lsb_lw.if_ready", 64'(if_ready), 64'(1'b1));
    tick();
    check_issue("lsb_add", 32'h14, 4'd5, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) begin
      tick();
      check_issue($sformatf("lsbdrain%0d", k), 32'h18 + 32'(4 * k), 4'((6 + k) % 16),
                  1'b1, 1'b0);
    end
    tick();
    check("lsbdrain_end.valid", 64'(dec_valid), 64'(1'b0));

    // rob_full holds a ROB-only JAL at head.
    rob_full = 1'b1;
    drive(1'b1, I_JAL, 32'h200);
    tick();
    check("jal_hold0.valid", 64'(dec_valid), 64'(1'b0));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("jal_hold1.valid", 64'(dec_valid), 64'(1'b0));
    tick();
    check("jal_hold2.valid", 64'(dec_valid), 64'(1'b0));
    rob_full = 1'b0;
    tick();
    check_issue("jal", 32'h200, 4'd4, 1'b0, 1'b0);

    // Advance rob_tail to 9, queue 6, then rollback with a concurrent push.
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, I_ADDI, 32'h300 + 32'(4 * k));
      tick();
      if (k >= 1) check_issue($sformatf("pre_rb%0d", k), 32'h300 + 32'(4 * (k - 1)),
                              4'(4 + k), 1'b1, 1'b0);
    end
    rob_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, I_ADDI, 32'h400 + 32'(4 * k));
      tick();
    end
    check("rb_queued.valid", 64'(dec_valid), 64'(1'b0));
    rollback = 1'b1; rob_full = 1'b0;
    drive(1'b1, I_ADDI, 32'h500);
    tick();
    check("rb.valid", 64'(dec_valid), 64'(1'b0));
    check("rb.if_ready", 64'(if_ready), 64'(1'b1));
    rollback = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("rb_empty.valid", 64'(dec_valid), 64'(1'b0));
    drive(1'b1, I_ADDI, 32'h600);
    tick();
    check("rb_push.valid", 64'(dec_valid), 64'(1'b0));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_issue("rb_next", 32'h600, 4'd0, 1'b1, 1'b0);

    // rdy low for 3 cycles mid-stream.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, I_ADDI, 32'h700 + 32'(4 * k));
      tick();
    end
    check_issue("rdy_pre", 32'h704, 4'd2, 1'b1, 1'b0);
    rdy = 1'b0;
    drive(1'b1, I_ADDI, 32'hbad0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_issue($sformatf("rdy_frz%0d", k), 32'h704, 4'd2, 1'b1, 1'b0);
      check($sformatf("rdy_frz%0d.if_ready", k), 64'(if_ready), 64'(1'b1));
    end
    rdy = 1'b1;
    drive(1'b1, I_ADDI, 32'h70c);
    tick();
    check_issue("rdy_res0", 32'h708, 4'd3, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_issue("rdy_res1", 32'h70c, 4'd4, 1'b1, 1'b0);
    tick();
    check("rdy_res2.valid", 64'(dec_valid), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Sequences instruction issue between IFetch and Decoder in the Tomasulo core. It buffers fetched instructions in an in-order queue and allocates ROB tail positions. It presents one instruction per cycle to Decoder only when the ROB and the target unit (RS or LSB) can accept it, and flushes everything on rollback.

Parameters:
IQ_DEPTH, 16, instruction queue entries (power of two)
IQ_WID, 4, log2(IQ_DEPTH)
ROB_SIZE, 16, ROB entries; dec_rob_pos is `ROB_WID wide and wraps at ROB_SIZE

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low freezes all state
rollback  in  1  misprediction flush from ROB
if_valid  in  1  IFetch offers an instruction
if_inst  in  `INST_WID  fetched instruction
if_pc  in  `ADDR_WID  its pc
if_pre_j  in  1  predicted-taken flag
if_ready  out  1  queue can accept (count < IQ_DEPTH)
rob_full  in  1  ROB cannot accept another entry (includes any entry issued this cycle)
rs_full  in  1  RS cannot accept (same convention)
lsb_full  in  1  LSB cannot accept (same convention)
dec_valid  out  1  one-cycle issue strobe to Decoder (inst_done)
dec_inst  out  `INST_WID  issued instruction
dec_pc  out  `ADDR_WID  issued pc
dec_pre_j  out  1  issued prediction flag
dec_rob_pos  out  `ROB_WID  ROB slot allocated to the issued instruction
dec_to_rs  out  1  instruction targets RS
dec_to_lsb  out  1  instruction targets LSB

Behaviour:
- Reset, async on rst high: head = 0, tail = 0, count = 0, rob_tail = 0, every dec_* output = 0. if_ready is 1 once reset is released.
- if_ready = (count != IQ_DEPTH). Combinational from count, not from if_valid.
- Push at a clk edge when rdy && !rollback && if_valid && if_ready. The entry is written at tail, tail wraps IQ_DEPTH-1 -> 0, and count increments. No write bypass when full.
- Head classification from head inst[6:0]:
  - LSB: L (0000011), S (0100011).
  - RS: CAL (0110011), CALI (0010011), B (1100011), AUIPC (0010111), JALR (1100111).
  - ROB-only: LUI (0110111), JAL (1101111), and any other opcode.
- can_issue = count != 0 && !rob_full && !(class==RS && rs_full) && !(class==LSB && lsb_full).
- At an edge with rdy && !rollback && can_issue:
  - dec_valid <= 1.
  - dec_inst/pc/pre_j <= head entry.
  - dec_to_rs / dec_to_lsb <= class bits.
  - dec_rob_pos <= rob_tail, then rob_tail increments mod ROB_SIZE.
  - head wraps and count decrements.
  Otherwise dec_valid <= 0 and the other dec_* outputs hold their values.
- Latency: pushed at edge N, visible at head in cycle N..N+1, dec_valid high in the cycle after edge N+1 (2 cycles minimum).
- Simultaneous push and issue in one edge: count unchanged, both pointers advance.
- Push into an empty queue cannot issue on the same edge (no bypass).
- rollback at an edge overrides push and issue: head = tail = count = 0, rob_tail = 0, dec_valid <= 0. The ROB clears itself on the same edge.
- rdy low: no register changes, dec_valid holds; downstream is likewise frozen.
- Throughput: 1 instruction/cycle sustained when no full flag is asserted.

Decomposition:
- Opcode constants (OPCODE_L/S/CAL/CALI/B/LUI/AUIPC/JAL/JALR) and `INST_WID/`ADDR_WID/`ROB_WID belong in the shared def.v include; no new literals in this block.
- Sub-module inst_queue: a circular FIFO with parameters IQ_DEPTH/IQ_WID.
  - Ports: push, pop, flush, and {inst, pc, pre_j} data in/out.
  - Outputs: full, empty.
- issue_ctrl holds the classification, the can_issue logic, the rob_tail counter and the output registers.

Test Plan:
- Reset mid-stream with 5 entries queued and dec_valid=1: all dec_* = 0 and if_ready=1 immediately; next push of pc 0x0 issues with dec_rob_pos=0.
- Push 20 back-to-back ADDI (0x00100093) with all full flags low: dec_valid high for 20 consecutive cycles after 2-cycle latency; dec_rob_pos runs 0..15,0..3; if_ready never drops.
- Hold lsb_full=1, queue LW at pc 0x10 then ADD at pc 0x14: nothing issues; queue fills to 16 and if_ready=0. Drop lsb_full: LW issues with dec_to_lsb=1, then ADD with dec_to_rs=1, in order.
- Assert rob_full with JAL (ROB-only) at head: no issue. Release: JAL issues with dec_to_rs=0 and dec_to_lsb=0.
- With 6 entries queued and rob_tail=9, assert rollback together with if_valid: next cycle count=0, dec_valid=0, the pushed entry is discarded, and the next issue gets dec_rob_pos=0.
- rdy=0 for 3 cycles mid-stream: dec_valid, pointers and count frozen; the stream resumes unchanged when rdy=1.
